apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced termination; legal range 2..255.
REQ-004 rclk  in  1  single clock for all logic.
REQ-005 rrst_n  in  1  reset, synchronous to rclk, active-low.
REQ-006 cmd_rdata  in  ADDR_W+DATA_W+1  command from the command FIFO: [ADDR_W+DATA_W]=write flag, [ADDR_W+DATA_W-1:DATA_W]=addr, [DATA_W-1:0]=wdata; valid the cycle after cmd_rinc.
REQ-007 cmd_rempty  in  1  command FIFO empty.
REQ-008 cmd_rinc  out  1  command FIFO pop.
REQ-009 resp_wdata  out  DATA_W+2  response: [DATA_W+1]=write flag, [DATA_W]=slverr, [DATA_W-1:0]=read data.
REQ-010 resp_wfull  in  1  response FIFO full.
REQ-011 resp_winc  out  1  response FIFO push.
REQ-012 paddr  out  ADDR_W  APB address.
REQ-013 psel  out  1  APB select.
REQ-014 penable  out  1  APB enable.
REQ-015 pwrite  out  1  APB direction, 1 = write.
REQ-016 pwdata  out  DATA_W  APB write data.
REQ-017 prdata  in  DATA_W  APB read data.
REQ-018 pready  in  1  APB ready.
REQ-019 pslverr  in  1  APB error, sampled only with pready.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 States SHALL be IDLE, FETCH, SETUP, ACCESS, RESP; one transfer in flight at a time.
REQ-022 IDLE: cmd_rinc SHALL be combinationally high when cmd_rempty=0; next state FETCH; otherwise stay in IDLE.
REQ-023 cmd_rinc SHALL never be high outside IDLE and SHALL be high for exactly one cycle per command.
REQ-024 FETCH: at the clock edge, paddr, pwrite and pwdata SHALL be loaded from cmd_rdata and psel set to 1; next state SETUP.
REQ-025 Reads SHALL drive pwdata=0.
REQ-026 SETUP: psel=1, penable=0 for exactly one cycle; next state ACCESS with penable=1.
REQ-027 paddr, pwrite, pwdata and psel SHALL be stable from SETUP through the last ACCESS cycle.
REQ-028 ACCESS with pready=1: at the edge, psel and penable SHALL clear, slverr SHALL capture pslverr, and read data SHALL capture prdata (0 for writes); next state RESP.
REQ-029 ACCESS wait-counter SHALL be 8 bits, cleared on entering ACCESS and incremented each cycle with pready=0.
REQ-030 When the counter reaches TIMEOUT-1 with pready=0, the transfer SHALL terminate as in REQ-028 with slverr=1 and read data=0.
REQ-031 pready=1 in the timeout cycle SHALL take priority over timeout.
REQ-032 RESP: resp_winc SHALL be combinationally high when resp_wfull=0; resp_wdata SHALL be registered and stable throughout RESP.
REQ-033 RESP SHALL stay in RESP while resp_wfull=1, and SHALL go to IDLE on the push edge.
REQ-034 Minimum spacing: 5 cycles per transfer with pready=1 in the first ACCESS cycle; no bus idle cycle beyond IDLE/FETCH/RESP.

Reset
REQ-035 While rrst_n=0 at an edge: state=IDLE; psel, penable, pwrite, cmd_rinc, resp_winc, busy=0; paddr, pwdata, resp_wdata=0; counter=0.
REQ-036 Reset mid-transfer SHALL drop psel/penable at that edge and push no response; a command popped before reset is discarded.

Verification
REQ-037 Write 0x10=0xA5A5A5A5, pready=1 immediately -> SETUP cycle psel=1/penable=0, one ACCESS cycle, resp_wdata={1,0,0}, 5 cycles total.
REQ-038 Read 0x20, pready after 3 wait cycles, prdata=0x12345678, pslverr=1 -> resp_wdata={0,1,0x12345678}; paddr stable across all ACCESS cycles.
REQ-039 Read with pready held 0, TIMEOUT=16 -> termination after 16 ACCESS cycles, resp_wdata={0,1,0}; repeat with pready=1 in cycle 16 -> slverr=pslverr.
REQ-040 resp_wfull=1 for 4 cycles in RESP -> resp_winc stays 0, resp_wdata stable, single push when full drops, no cmd_rinc meanwhile.
REQ-041 Three queued commands with cmd_rempty=0 -> exactly three cmd_rinc pulses, in-order APB transfers, three responses.
REQ-042 rrst_n low in ACCESS -> psel=penable=0 next cycle, no resp_winc, next queued command starts cleanly after reset release.

Source files
------------

// File: rtl/apb_master.sv
// APB master: pops one command from a FIFO, runs one APB transfer with a
// bounded wait, and pushes the response into a FIFO.
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic [ADDR_W+DATA_W:0]   cmd_rdata,
  input  logic                     cmd_rempty,
  output logic                     cmd_rinc,
  output logic [DATA_W+1:0]        resp_wdata,
  input  logic                     resp_wfull,
  output logic                     resp_winc,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t              state;
  logic [7:0]          wait_cnt;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  assign cmd_write = cmd_rdata[ADDR_W+DATA_W];
  assign cmd_addr  = cmd_rdata[ADDR_W+DATA_W-1:DATA_W];
  assign cmd_wdata = cmd_rdata[DATA_W-1:0];

  // FIFO handshakes are gated by reset so no pop or push escapes during reset
  assign cmd_rinc  = rrst_n && (state == IDLE) && !cmd_rempty;
  assign resp_winc = rrst_n && (state == RESP) && !resp_wfull;
  assign busy      = (state != IDLE);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_wdata <= '0;
      wait_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cmd_rempty) state <= FETCH;
        end
        FETCH: begin
          paddr  <= cmd_addr;
          pwrite <= cmd_write;
          pwdata <= cmd_wdata & {DATA_W{cmd_write}};
          psel   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the timeout in the final wait cycle
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_wdata <= {pwrite, pslverr, prdata & {DATA_W{!pwrite}}};
            state      <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_wdata <= {pwrite, 1'b1, {DATA_W{1'b0}}};
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (!resp_wfull) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
